buzzer_arbiter: RTL and testbench



---
 rtl/buzzer_arbiter_if.sv | 42 ++++
 rtl/buzzer_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_buzzer_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buzzer_arbiter_if.sv
// -----------------------------------------------------------------------------
// buzzer_arbiter_if
// Bundles the requester-facing signals of buzzer_arbiter.
//
// Handshake: req[i] is a level request. The arbiter answers with ack[i] (one-hot,
// high for as long as requester i owns the buzzer). A tone is finished when
// done[i] pulses for one cycle on the edge ack[i] falls; a requester that wants
// exactly one tone drops req[i] when it sees done[i]. Dropping req[i] while
// ack[i] is high aborts the tone (ack falls, no done pulse). hp_bus/dur_bus
// are sampled only on the grant edge.
//
// Signals:
//   req      3   level requests, bit 0 highest priority
//   hp_bus   51  three 17-bit half-periods, requester i at [17i+16:17i]
//   dur_bus  36  three 12-bit durations in ticks, requester i at [12i+11:12i]
//   ack      3   one-hot ownership
//   done     3   one-cycle completion pulse
//   grant    2   current owner index, 2'b11 when none
//   busy     1   arbiter not idle
//   buzz     1   square wave to the piezo pin
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface buzzer_arbiter_if;
  logic [2:0]  req;
  logic [50:0] hp_bus;
  logic [35:0] dur_bus;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic [1:0]  grant;
  logic        busy;
  logic        buzz;

  modport master (
    output req, hp_bus, dur_bus,
    input  ack, done, grant, busy, buzz
  );

  modport slave (
    input  req, hp_bus, dur_bus,
    output ack, done, grant, busy, buzz
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// buzzer_arbiter
// Shares one piezo buzzer between three tone requesters (alarm, timer expiry,
// key click) with fixed priority (index 0 highest). The granted requester's
// half-period and duration are latched at grant; the tone is generated
// straight from clk_25M and every tone is followed by a silent gap.
//
// Parameters:
//   TICK_DIV   clk_25M cycles per duration tick
//   GAP_TICKS  silent ticks after every tone (completed or aborted), >= 1
// Ports:
//   clk_25M    system clock
//   reset      asynchronous, active-high
//   bus        buzzer_arbiter_if.slave (req/hp_bus/dur_bus in,
//              ack/done/grant/busy/buzz out, all outputs registered)
//   state_dbg  current FSM state (0 IDLE, 1 PLAY, 2 GAP)
// Build option:
//   BUZZER_PREEMPT_EN  when defined, a higher-priority request takes the
//                      buzzer immediately during PLAY (no gap, no done).
// -----------------------------------------------------------------------------
module buzzer_arbiter #(
  parameter int TICK_DIV  = 25000,
  parameter int GAP_TICKS = 20
) (
  input  logic            clk_25M,
  input  logic            reset,
  buzzer_arbiter_if.slave bus,
  output logic [1:0]      state_dbg
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [16:0]        hp_l_q, hp_l_n;
  logic [11:0]        dur_l_q, dur_l_n;
  logic [16:0]        hp_cnt_q, hp_cnt_n;
  logic [11:0]        tick_q, tick_n;
  logic [PRE_W-1:0]   pre_q, pre_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [2:0]         ack_q, ack_n;
  logic [2:0]         done_q, done_n;
  logic [1:0]         grant_q, grant_n;
  logic               busy_q, busy_n;
  logic               buzz_q, buzz_n;

  logic [1:0]         win;
  logic [16:0]        hp_sel;
  logic [11:0]        dur_sel;
  logic               pre_term;
  logic [12:0]        tick_inc;
  logic               complete;
  logic               owner_req;
  logic               preempt;
  logic               do_start;
  logic               do_gap;

  // Lowest set index wins; value is only used when some req bit is high.
  always_comb begin
    win = 2'd2;
    if (bus.req[0])      win = 2'd0;
    else if (bus.req[1]) win = 2'd1;
  end

  always_comb begin
    hp_sel  = bus.hp_bus[50:34];
    dur_sel = bus.dur_bus[35:24];
    case (win)
      2'd0: begin hp_sel = bus.hp_bus[16:0];  dur_sel = bus.dur_bus[11:0];  end
      2'd1: begin hp_sel = bus.hp_bus[33:17]; dur_sel = bus.dur_bus[23:12]; end
      default: ;
    endcase
  end

  assign pre_term  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign tick_inc  = {1'b0, tick_q} + {12'd0, pre_term};
  // First term covers dur_l == 0 (completes on the first PLAY cycle); the
  // second fires on the edge where the tick counter would reach dur_l.
  assign complete  = (tick_q == dur_l_q) || (tick_inc == {1'b0, dur_l_q});
  // ack_q is one-hot on the owner, so this is req[owner] without indexing.
  assign owner_req = |(bus.req & ack_q);

`ifdef BUZZER_PREEMPT_EN
  assign preempt = (|bus.req) && (win < grant_q);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_n  = state_q;
    hp_l_n   = hp_l_q;
    dur_l_n  = dur_l_q;
    hp_cnt_n = hp_cnt_q;
    tick_n   = tick_q;
    pre_n    = pre_q;
    gap_n    = gap_q;
    ack_n    = ack_q;
    done_n   = 3'b000;
    grant_n  = grant_q;
    busy_n   = busy_q;
    buzz_n   = buzz_q;
    do_start = 1'b0;
    do_gap   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) do_start = 1'b1;
      end
      PLAY: begin
        pre_n  = pre_term ? '0 : pre_q + PRE_W'(1);
        tick_n = tick_inc[11:0];
        if (hp_l_q == 17'd0) begin
          hp_cnt_n = 17'd0;
          buzz_n   = 1'b0;
        end else if (hp_cnt_q == hp_l_q - 17'd1) begin
          hp_cnt_n = 17'd0;
          buzz_n   = ~buzz_q;
        end else begin
          hp_cnt_n = hp_cnt_q + 17'd1;
        end
        if (preempt) begin
          do_start = 1'b1;
        end else if (!owner_req) begin
          do_gap = 1'b1;
        end else if (complete) begin
          do_gap = 1'b1;
          done_n = ack_q;
        end
      end
      GAP: begin
        pre_n = pre_term ? '0 : pre_q + PRE_W'(1);
        if (pre_term) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            gap_n   = '0;
          end else begin
            gap_n = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_start) begin
      state_n  = PLAY;
      ack_n    = 3'b001 << win;
      grant_n  = win;
      busy_n   = 1'b1;
      buzz_n   = 1'b0;
      hp_l_n   = hp_sel;
      dur_l_n  = dur_sel;
      hp_cnt_n = 17'd0;
      tick_n   = 12'd0;
      pre_n    = '0;
    end

    if (do_gap) begin
      state_n  = GAP;
      ack_n    = 3'b000;
      grant_n  = 2'b11;
      buzz_n   = 1'b0;
      hp_cnt_n = 17'd0;
      tick_n   = 12'd0;
      pre_n    = '0;
      gap_n    = '0;
    end
  end

  always_ff @(posedge clk_25M or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hp_l_q   <= 17'd0;
      dur_l_q  <= 12'd0;
      hp_cnt_q <= 17'd0;
      tick_q   <= 12'd0;
      pre_q    <= '0;
      gap_q    <= '0;
      ack_q    <= 3'b000;
      done_q   <= 3'b000;
      grant_q  <= 2'b11;
      busy_q   <= 1'b0;
      buzz_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      hp_l_q   <= hp_l_n;
      dur_l_q  <= dur_l_n;
      hp_cnt_q <= hp_cnt_n;
      tick_q   <= tick_n;
      pre_q    <= pre_n;
      gap_q    <= gap_n;
      ack_q    <= ack_n;
      done_q   <= done_n;
      grant_q  <= grant_n;
      busy_q   <= busy_n;
      buzz_q   <= buzz_n;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.done  = done_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.buzz  = buzz_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buzzer_arbiter
// Directed tests for buzzer_arbiter with TICK_DIV=10, GAP_TICKS=2. The driver
// pushes hand-computed event records into exp_q; the monitor condenses what
// the DUT does into the same records (grant, tone, gap) and pops/compares.
//   grant: owner index, ack one-hot with grant, idle samples before grant
//          (8'hFF when no busy cycle has happened since reset)
//   tone : owner index, ack length, buzz transitions (incl. the final drop),
//          done pulses seen for the owner
//   gap  : samples with busy high and no owner, clean = buzz 0 and grant 3
// -----------------------------------------------------------------------------
module tb_buzzer_arbiter;
  localparam int TICK_DIV  = 10;
  localparam int GAP_TICKS = 2;
  localparam int W         = 32;

  logic       clk_25M = 1'b0;
  logic       reset   = 1'b0;
  logic [1:0] state_dbg;

  buzzer_arbiter_if bus();

  buzzer_arbiter #(.TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk_25M  (clk_25M),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  always #20 clk_25M = ~clk_25M;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] mk_grant(input logic [1:0] idx, input logic [7:0] idle);
    return {2'd1, idx, 1'b1, 19'd0, idle};
  endfunction

  function automatic logic [W-1:0] mk_tone(input logic [1:0] idx, input logic [11:0] len,
                                           input logic [7:0] tog, input logic [3:0] dn);
    return {2'd2, idx, len, tog, 4'd0, dn};
  endfunction

  function automatic logic [W-1:0] mk_gap(input logic [11:0] len, input logic clean);
    return {2'd3, 2'd0, len, 15'd0, clean};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic score(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s at %0t: unexpected event %h, expected queue empty", name, $time, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic       in_tone = 1'b0;
  logic       in_gap  = 1'b0;
  logic       since_reset = 1'b1;
  int         idle_cnt = 0;
  logic [2:0] prev_ack = 3'b000;
  logic       prev_buzz = 1'b0;
  logic [1:0] cur_idx = 2'd0;
  int         ack_len = 0;
  int         tog_cnt = 0;
  int         done_cnt = 0;
  int         gap_len = 0;
  logic       gap_clean = 1'b1;
  logic [7:0] idle8;

  always @(negedge clk_25M) begin
    if (reset) begin
      in_tone     = 1'b0;
      in_gap      = 1'b0;
      since_reset = 1'b1;
      idle_cnt    = 0;
      prev_ack    = 3'b000;
      prev_buzz   = 1'b0;
    end else begin
      idle8 = since_reset ? 8'hFF : 8'(idle_cnt);
      if (in_gap) begin
        if (bus.busy && bus.ack == 3'b000) begin
          gap_len++;
          if (bus.buzz !== 1'b0 || bus.grant !== 2'b11) gap_clean = 1'b0;
        end else begin
          score("gap", mk_gap(12'(gap_len), gap_clean));
          in_gap = 1'b0;
        end
      end
      if (in_tone && bus.ack != prev_ack) begin
        if (bus.buzz != prev_buzz) tog_cnt++;
        if (bus.done[cur_idx]) done_cnt++;
        score("tone", mk_tone(cur_idx, 12'(ack_len), 8'(tog_cnt), 4'(done_cnt)));
        in_tone = 1'b0;
        if (bus.ack == 3'b000) begin
          in_gap    = 1'b1;
          gap_len   = 1;
          gap_clean = (bus.buzz == 1'b0) && (bus.grant == 2'b11) && bus.busy;
        end
      end else if (in_tone) begin
        ack_len++;
        if (bus.buzz != prev_buzz) tog_cnt++;
        if (bus.done[cur_idx]) done_cnt++;
      end
      if (!in_tone && bus.ack != 3'b000) begin
        cur_idx = bus.grant;
        score("grant", {2'd1, bus.grant, (bus.ack == (3'b001 << bus.grant)), 19'd0, idle8});
        in_tone  = 1'b1;
        ack_len  = 1;
        tog_cnt  = 0;
        done_cnt = bus.done[bus.grant] ? 1 : 0;
      end
      if (bus.busy) begin
        idle_cnt    = 0;
        since_reset = 1'b0;
      end else if (idle_cnt < 250) begin
        idle_cnt++;
      end
      prev_ack  = bus.ack;
      prev_buzz = bus.buzz;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic set_tone(input int i, input logic [16:0] hp, input logic [11:0] dur);
    bus.hp_bus[17*i +: 17]  = hp;
    bus.dur_bus[12*i +: 12] = dur;
  endtask

  task automatic wait_done(input int i, input int limit);
    int k = 0;
    do begin
      @(negedge clk_25M);
      k++;
    end while (!bus.done[i] && k < limit);
    if (!bus.done[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done%0d at %0t: no done pulse within %0d cycles", i, $time, limit);
    end
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    do begin
      @(negedge clk_25M);
      k++;
    end while (bus.busy && k < limit);
    if (bus.busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle at %0t: busy still %b after %0d cycles", $time, bus.busy, limit);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outs"},
          32'({bus.ack, bus.done, bus.grant, bus.busy, bus.buzz}),
          32'({3'b000, 3'b000, 2'b11, 1'b0, 1'b0}));
    check({name, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    bus.req     = 3'b000;
    bus.hp_bus  = '0;
    bus.dur_bus = '0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk_25M);
    #3 reset = 1'b0;
    @(negedge clk_25M);

    // Single tone; bus changes during PLAY must be ignored.
    set_tone(1, 17'd5, 12'd3);
    exp_q.push_back(mk_grant(2'd1, 8'hFF));
    exp_q.push_back(mk_tone(2'd1, 12'd30, 8'd6, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req[1] = 1'b1;
    repeat (3) @(negedge clk_25M);
    set_tone(1, 17'd2, 12'd9);
    wait_done(1, 100);
    bus.req[1] = 1'b0;
    wait_idle(100);

    // Priority: 0 and 2 together; 2 granted one cycle after the gap.
    set_tone(0, 17'd2, 12'd1);
    set_tone(2, 17'd3, 12'd1);
    exp_q.push_back(mk_grant(2'd0, 8'd1));
    exp_q.push_back(mk_tone(2'd0, 12'd10, 8'd4, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    exp_q.push_back(mk_grant(2'd2, 8'd1));
    exp_q.push_back(mk_tone(2'd2, 12'd10, 8'd4, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req = 3'b101;
    wait_done(0, 100);
    bus.req[0] = 1'b0;
    wait_done(2, 200);
    bus.req[2] = 1'b0;
    wait_idle(100);

    // Abort 12 cycles into PLAY while buzz is high.
    set_tone(1, 17'd3, 12'd5);
    exp_q.push_back(mk_grant(2'd1, 8'd1));
    exp_q.push_back(mk_tone(2'd1, 12'd12, 8'd4, 4'd0));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req[1] = 1'b1;
    repeat (12) @(negedge clk_25M);
    bus.req[1] = 1'b0;
    wait_idle(100);

    // dur = 0: one-cycle ack with done, no toggles.
    set_tone(2, 17'd5, 12'd0);
    exp_q.push_back(mk_grant(2'd2, 8'd1));
    exp_q.push_back(mk_tone(2'd2, 12'd1, 8'd0, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req[2] = 1'b1;
    wait_done(2, 50);
    bus.req[2] = 1'b0;
    wait_idle(100);

    // hp = 0: silent play for two ticks.
    set_tone(0, 17'd0, 12'd2);
    exp_q.push_back(mk_grant(2'd0, 8'd1));
    exp_q.push_back(mk_tone(2'd0, 12'd20, 8'd0, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req[0] = 1'b1;
    wait_done(0, 100);
    bus.req[0] = 1'b0;
    wait_idle(100);

    // Requester 2 playing, requester 0 arrives 5 cycles in.
    set_tone(2, 17'd4, 12'd3);
    set_tone(0, 17'd2, 12'd1);
    exp_q.push_back(mk_grant(2'd2, 8'd1));
`ifdef BUZZER_PREEMPT_EN
    exp_q.push_back(mk_tone(2'd2, 12'd5, 8'd2, 4'd0));
    exp_q.push_back(mk_grant(2'd0, 8'd0));
    exp_q.push_back(mk_tone(2'd0, 12'd10, 8'd4, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req[2] = 1'b1;
    repeat (5) @(negedge clk_25M);
    bus.req[0] = 1'b1;
    wait_done(0, 100);
    bus.req = 3'b000;
    wait_idle(100);
`else
    exp_q.push_back(mk_tone(2'd2, 12'd30, 8'd8, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    exp_q.push_back(mk_grant(2'd0, 8'd1));
    exp_q.push_back(mk_tone(2'd0, 12'd10, 8'd4, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req[2] = 1'b1;
    repeat (5) @(negedge clk_25M);
    bus.req[0] = 1'b1;
    wait_done(2, 100);
    bus.req[2] = 1'b0;
    wait_done(0, 100);
    bus.req[0] = 1'b0;
    wait_idle(100);
`endif

    // Reset in the middle of a tone: outputs clear without a clock edge.
    set_tone(1, 17'd5, 12'd3);
    exp_q.push_back(mk_grant(2'd1, 8'd1));
    bus.req[1] = 1'b1;
    repeat (8) @(negedge clk_25M);
    #3 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    bus.req = 3'b000;
    repeat (2) @(negedge clk_25M);
    #3 reset = 1'b0;
    @(negedge clk_25M);

    // Function restored after reset.
    set_tone(0, 17'd0, 12'd0);
    exp_q.push_back(mk_grant(2'd0, 8'hFF));
    exp_q.push_back(mk_tone(2'd0, 12'd1, 8'd0, 4'd1));
    exp_q.push_back(mk_gap(12'd20, 1'b1));
    bus.req[0] = 1'b1;
    wait_done(0, 50);
    bus.req[0] = 1'b0;
    wait_idle(100);

    repeat (3) @(negedge clk_25M);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
